// File: rtl/game_bcd_counter.sv
// game_bcd_counter: multi-digit BCD counter for game timers and scoreboards.
// MODE 0 counts prescaler ticks and MODE 1 counts rising edges of event_in.
// SATURATE selects between wrapping to all-0s and holding at all-9s.
// Defining GAME_BCD_COUNTER_SEG7_EN adds an active-low 7-segment output,
// seg, with one 7-bit group per digit in gfedcba order.
module game_bcd_counter #(
   parameter int DIGITS   = 4,
   parameter int DIV      = 50000000,
   parameter int MODE     = 0,
   parameter int SATURATE = 0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  enable,
   input  logic                  event_in,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  tick,
   output logic                  overflow,
   output logic                  at_max
`ifdef GAME_BCD_COUNTER_SEG7_EN
   ,
   output logic [7*DIGITS-1:0]   seg
`endif
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0]       r_presc;
   logic [4*DIGITS-1:0] r_digits;
   logic                r_evPrev;
   logic                r_overflow;

   logic                w_tick;
   logic                w_edge;
   logic                w_inc;
   logic                w_allNines;
   logic [4*DIGITS-1:0] w_incDigits;

   // The tick is the last prescaler count. It is gated by enable so that a
   // prescaler frozen at its terminal value does not stretch the pulse.
   assign w_tick = enable && (r_presc == PW'(DIV - 1));

   // A rising edge is the current event level high while the sampled level from the previous cycle was low.
   assign w_edge = event_in & ~r_evPrev;

   // The increment source depends on MODE. Increments are suppressed while enable is low.
   assign w_inc = enable & ((MODE == 0) ? w_tick : w_edge);

   // The counter is at its maximum only when every digit reads 9.
   always_comb begin
      w_allNines = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_digits[4*k +: 4] != 4'd9) begin
            w_allNines = 1'b0;
         end
      end
   end

   // Decimal ripple increment. A carry enters digit 0, and each 9 it reaches becomes 0 and
   // passes the carry upward. The first digit below 9 absorbs the carry. A digit that is
   // somehow above 9 is treated as 9 so that the result never holds an illegal code.
   always_comb begin
      logic carry;
      w_incDigits = r_digits;
      carry       = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (r_digits[4*k +: 4] >= 4'd9) begin
               w_incDigits[4*k +: 4] = 4'd0;
            end else begin
               w_incDigits[4*k +: 4] = r_digits[4*k +: 4] + 4'd1;
               carry                 = 1'b0;
            end
         end
      end
   end

   // The prescaler counts 0..DIV-1 while enabled. Reset and clear both restart it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
      end else if (clear) begin
         r_presc <= '0;
      end else if (enable) begin
         if (r_presc == PW'(DIV - 1)) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   // The edge register samples event_in every cycle, including while disabled or clearing.
   // An edge seen in those cycles is therefore consumed and lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_evPrev <= 1'b0;
      end else begin
         r_evPrev <= event_in;
      end
   end

   // The count and overflow pulse update one edge after the increment cause. Clear beats a
   // simultaneous increment. At all-9s the counter either wraps to zero or holds, and overflow
   // pulses in both cases.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_digits   <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_digits   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_inc & w_allNines;
         if (w_inc) begin
            if (w_allNines) begin
               if (SATURATE == 0) begin
                  r_digits <= '0;
               end
            end else begin
               r_digits <= w_incDigits;
            end
         end
      end
   end

   assign digits   = r_digits;
   assign tick     = w_tick;
   assign overflow = r_overflow;
   assign at_max   = w_allNines;

`ifdef GAME_BCD_COUNTER_SEG7_EN
   // Active-low segment pattern for one BCD digit, in gfedcba order. Codes above 9 are blanked.
   function automatic logic [6:0] segOf(input logic [3:0] d);
      case (d)
         4'd0:    segOf = 7'b1000000;
         4'd1:    segOf = 7'b1111001;
         4'd2:    segOf = 7'b0100100;
         4'd3:    segOf = 7'b0110000;
         4'd4:    segOf = 7'b0011001;
         4'd5:    segOf = 7'b0010010;
         4'd6:    segOf = 7'b0000010;
         4'd7:    segOf = 7'b1111000;
         4'd8:    segOf = 7'b0000000;
         4'd9:    segOf = 7'b0011000;
         default: segOf = 7'b1111111;
      endcase
   endfunction

   // Each digit is decoded independently and combinationally from the registered count.
   always_comb begin
      seg = '1;
      for (int k = 0; k < DIGITS; k++) begin
         seg[7*k +: 7] = segOf(r_digits[4*k +: 4]);
      end
   end
`endif

endmodule

// File: tb/tb_game_bcd_counter.sv
// tb_game_bcd_counter: directed bench for game_bcd_counter.
// Three instances share one set of inputs:
//   uTimer - 4-digit timer with DIV=4
//   uWrap  - 2-digit score counter that wraps
//   uSat   - 2-digit score counter that saturates
// The score counters use a scoreboard queue of expected values.
module tb_game_bcd_counter;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        enable;
   logic        eventIn;

   logic [15:0] timerDigits;
   logic        timerTick;
   logic        timerOvf;
   logic        timerMax;
   logic [7:0]  wrapDigits;
   logic        wrapTick;
   logic        wrapOvf;
   logic        wrapMax;
   logic [7:0]  satDigits;
   logic        satTick;
   logic        satOvf;
   logic        satMax;
`ifdef GAME_BCD_COUNTER_SEG7_EN
   logic [27:0] timerSeg;
   logic [13:0] wrapSeg;
   logic [13:0] satSeg;
`endif

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   typedef struct {
      logic [7:0] wrapD;
      logic       wrapM;
      logic       wrapO;
      logic [7:0] satD;
      logic       satM;
      logic       satO;
   } exp_t;

   exp_t sb[$];

   game_bcd_counter #(.DIGITS(4), .DIV(4), .MODE(0), .SATURATE(0)) uTimer (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .event_in(eventIn),
      .digits(timerDigits), .tick(timerTick), .overflow(timerOvf), .at_max(timerMax)
`ifdef GAME_BCD_COUNTER_SEG7_EN
      , .seg(timerSeg)
`endif
   );

   game_bcd_counter #(.DIGITS(2), .DIV(4), .MODE(1), .SATURATE(0)) uWrap (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .event_in(eventIn),
      .digits(wrapDigits), .tick(wrapTick), .overflow(wrapOvf), .at_max(wrapMax)
`ifdef GAME_BCD_COUNTER_SEG7_EN
      , .seg(wrapSeg)
`endif
   );

   game_bcd_counter #(.DIGITS(2), .DIV(4), .MODE(1), .SATURATE(1)) uSat (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .event_in(eventIn),
      .digits(satDigits), .tick(satTick), .overflow(satOvf), .at_max(satMax)
`ifdef GAME_BCD_COUNTER_SEG7_EN
      , .seg(satSeg)
`endif
   );

   // Free-running clock with a 10-time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drives one cycle of inputs and returns 1 time unit after the next rising edge.
   task automatic applyStimulus(input logic rst, input logic clr, input logic en, input logic ev);
      reset   = rst;
      clear   = clr;
      enable  = en;
      eventIn = ev;
      @(posedge clk);
      #1;
   endtask

   // Compares one observed value against the value the bench expects.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Converts 0..99 to two BCD digits.
   function automatic logic [7:0] toBcd2(input int v);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = 4'(v / 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   // Pops one scoreboard entry and compares both score counters against it.
   task automatic checkScore(input int p);
      exp_t e;
      checkCount++;
      if (sb.size() == 0) begin
         failCount++;
         $error("[TB] FAIL scoreboard_empty pulse %0d: observed empty queue, expected an entry", p);
      end else begin
         passCount++;
         e = sb.pop_front();
         checkOutput($sformatf("wrap_digits_p%0d", p), 32'(wrapDigits), 32'(e.wrapD));
         checkOutput($sformatf("wrap_max_p%0d", p),    32'(wrapMax),    32'(e.wrapM));
         checkOutput($sformatf("wrap_ovf_p%0d", p),    32'(wrapOvf),    32'(e.wrapO));
         checkOutput($sformatf("sat_digits_p%0d", p),  32'(satDigits),  32'(e.satD));
         checkOutput($sformatf("sat_max_p%0d", p),     32'(satMax),     32'(e.satM));
         checkOutput($sformatf("sat_ovf_p%0d", p),     32'(satOvf),     32'(e.satO));
      end
   endtask

   initial begin
      int   wrapCnt;
      int   satCnt;
      exp_t e;

      // Hold reset for three cycles. Everything should read zero afterwards.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_digits",   32'(timerDigits), 32'h0000);
      checkOutput("reset_tick",     32'(timerTick),   32'h0);
      checkOutput("reset_overflow", 32'(timerOvf),    32'h0);
      checkOutput("reset_at_max",   32'(timerMax),    32'h0);
      checkOutput("reset_wrap",     32'(wrapDigits),  32'h00);

      // Run the timer for 40 enabled cycles. Tick is high after every 4th
      // edge, and 10 ticks bring the count to 0010.
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         checkOutput($sformatf("timer_tick_c%0d", i), 32'(timerTick), 32'((i % 4) == 3));
      end
      checkOutput("timer_digits_40", 32'(timerDigits), 32'h0010);

      // Drop enable. The count must freeze.
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("timer_frozen", 32'(timerDigits), 32'h0010);
      checkOutput("timer_frozen_tick", 32'(timerTick), 32'h0);

      // Send 100 single-cycle event pulses. Each expected result is queued as
      // the pulse is driven and compared once the count has updated.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      wrapCnt = 0;
      satCnt  = 0;
      for (int p = 1; p <= 100; p++) begin
         e.wrapO = (wrapCnt == 99);
         wrapCnt = (wrapCnt + 1) % 100;
         e.wrapD = toBcd2(wrapCnt);
         e.wrapM = (wrapCnt == 99);
         e.satO  = (satCnt == 99);
         if (satCnt < 99) satCnt++;
         e.satD  = toBcd2(satCnt);
         e.satM  = (satCnt == 99);
         sb.push_back(e);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
         checkScore(p);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         if (p == 100) begin
            checkOutput("wrap_ovf_one_cycle", 32'(wrapOvf), 32'h0);
            checkOutput("sat_ovf_one_cycle",  32'(satOvf),  32'h0);
            checkOutput("sat_hold_digits",    32'(satDigits), 32'h99);
         end
      end

      // A level held high for 10 cycles counts only once.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("held_level_once", 32'(wrapDigits), 32'h01);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      // Clear wins over a simultaneous edge. The edge is consumed.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("clear_over_edge", 32'(wrapDigits), 32'h00);
      checkOutput("clear_timer",     32'(timerDigits), 32'h0000);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("clear_edge_lost", 32'(wrapDigits), 32'h00);

      // An edge that arrives while disabled is lost.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("disabled_edge_lost", 32'(wrapDigits), 32'h00);

      // Reset beats an edge. The cleared edge register then sees the held
      // level as a fresh edge.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("reset_over_edge", 32'(wrapDigits), 32'h00);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("edge_after_reset", 32'(wrapDigits), 32'h01);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef GAME_BCD_COUNTER_SEG7_EN
      // Count to 79 and check the segment patterns for 9 and 7.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 79; p++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      end
      checkOutput("seg_digits_79", 32'(wrapDigits), 32'h79);
      checkOutput("seg_digit0", 32'(wrapSeg[6:0]),  32'(7'b0011000));
      checkOutput("seg_digit1", 32'(wrapSeg[13:7]), 32'(7'b1111000));
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/game_bcd_counter.md
GAME_BCD_COUNTER -- requirements
Module: game_bcd_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits, legal range 1..8.
REQ-002 SHALL have parameter DIV, default 50000000: prescaler period in clk cycles, legal range 2..2^28.
REQ-003 SHALL have parameter MODE, default 0: 0 = timer, counts prescaler ticks; 1 = score, counts event_in rising edges.
REQ-004 SHALL have parameter SATURATE, default 0: 0 = wrap at all-9s; 1 = hold at all-9s.
REQ-005 SHALL have port clk  input  1  sole clock; all logic is posedge clk.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port clear  input  1  synchronous game-restart clear of count and prescaler.
REQ-008 SHALL have port enable  input  1  permits counting; when low, all state holds.
REQ-009 SHALL have port event_in  input  1  score event level, synchronous to clk.
REQ-010 SHALL have port digits  output  4*DIGITS  BCD value, digit 0 in bits [3:0].
REQ-011 SHALL have port tick  output  1  one-cycle prescaler pulse.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse on an increment taken at all-9s.
REQ-013 SHALL have port at_max  output  1  high while digits is all-9s.

Function
REQ-014 SHALL run a prescaler from 0 to DIV-1 while enable=1; tick=1 for exactly the one cycle in which the prescaler equals DIV-1, and the prescaler returns to 0 on the next clock.
REQ-015 SHALL run the prescaler in both modes; in MODE 1 tick is informational only.
REQ-016 SHALL register event_in each cycle and detect a rising edge as current=1 with previous=0; a level held high SHALL produce exactly one increment.
REQ-017 SHALL update digits on the clock edge after the increment cause: tick in MODE 0, detected edge in MODE 1. Latency is 1 cycle.
REQ-018 SHALL perform decimal increment with ripple carry: digit k increments when all lower digits are 9, and every digit equal to 9 in that case becomes 0. Digits SHALL never hold a value above 9.
REQ-019 SHALL, on an increment at all-9s, set digits to all-0 when SATURATE=0, leave digits unchanged when SATURATE=1, and pulse overflow for 1 cycle in both cases.
REQ-020 SHALL, when clear=1, set digits=0, prescaler=0, tick=0 and overflow=0 on the next edge. clear overrides a simultaneous increment.
REQ-021 SHALL take clear regardless of enable.
REQ-022 SHALL, when enable=0, freeze the prescaler and suppress increments. The edge-detect register SHALL keep sampling, so an edge that occurs while disabled is lost.
REQ-023 SHALL derive at_max combinationally from digits.

Reset
REQ-024 SHALL, on reset=1, set digits=0, prescaler=0, the edge register=0, tick=0 and overflow=0 on the next edge. at_max is therefore 0.
REQ-025 SHALL give reset priority over clear, enable and event_in. Reset asserted mid-count SHALL abandon any pending increment.

Configuration
REQ-026 SHALL, with `define GAME_BCD_COUNTER_SEG7_EN`, add output seg of width 7*DIGITS: per-digit active-low 7-segment code with bit order gfedcba (0 = 1000000, 7 = 1111000, 9 = 0011000), combinational from digits.
REQ-027 SHALL, without that macro, have no seg port and no decode logic.

Verification
REQ-028 SHALL cover reset: DIGITS=4, DIV=4, reset held 3 cycles -> digits=0x0000, tick=0, overflow=0, at_max=0.
REQ-029 SHALL cover timer mode: MODE=0, DIV=4, enable=1 for 40 cycles after reset -> tick pulses every 4th cycle, digits=0x0010.
REQ-030 SHALL cover carry and wrap: DIGITS=2, MODE=1, SATURATE=0, 100 single-cycle event pulses -> 99th pulse gives 0x99 with at_max=1; 100th pulse gives 0x00 with a one-cycle overflow.
REQ-031 SHALL cover saturation: same as REQ-030 with SATURATE=1 -> digits stays 0x99, at_max=1, overflow pulses once on the 100th pulse.
REQ-032 SHALL cover edge and clear rules: event_in held high 10 cycles -> +1 only; clear and an event edge in the same cycle -> digits=0x0000.
REQ-033 SHALL cover decode with the macro defined: digits=0x0079 -> seg low digits = 0011000 (digit 0), 1111000 (digit 1).
